// File: rtl/exec_controller_if.sv
// Core-side bundle of the execution controller: breakpoint/PC/halt inputs
// coming from the core and the tick plus status outputs going back.
interface exec_controller_if #(
  parameter int ADDR_W = 32
);
  logic              bp_enable;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;
  logic              halt_req;
  logic              cpu_enable;
  logic [1:0]        state;
  logic              halted;
  logic              bp_hit;
  logic [31:0]       tick_count;

  // Controller side: observes the core, issues ticks and status.
  modport master (
    input  bp_enable, bp_addr, pc, halt_req,
    output cpu_enable, state, halted, bp_hit, tick_count
  );

  // Core/board side: supplies PC and breakpoint setup, consumes ticks.
  modport slave (
    output bp_enable, bp_addr, pc, halt_req,
    input  cpu_enable, state, halted, bp_hit, tick_count
  );
endinterface

// File: rtl/exec_controller.sv
// Execution controller: conditions the step button and run switch, then
// issues one-cycle clock-enable ticks to the core in RUN (divided rate),
// STEP (one tick per button press) or holds it in BREAK.
//
// Handshake: cpu_enable is a single-cycle qualifier with no back-pressure;
// the core advances exactly one instruction for every cycle it is high.
// The current FSM state is always visible on bus.state for checkers.
module exec_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000,
  parameter int ADDR_W          = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_n,
  input  logic              run_sw,
  exec_controller_if.master bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  // Synchronizers (inactive values: step released = 1, run off = 0)
  logic step_s1_q, step_s1_d, step_s2_q, step_s2_d;
  logic run_s1_q, run_s1_d, run_s2_q, run_s2_d;

  // Debouncers
  logic            step_db_q, step_db_d;
  logic [DB_W-1:0] step_cnt_q, step_cnt_d;
  logic            run_db_q, run_db_d;
  logic [DB_W-1:0] run_cnt_q, run_cnt_d;
  logic            step_press;

  // Control state
  state_t          state_q, state_d;
  logic            ret_break_q, ret_break_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            cpu_enable_q, cpu_enable_d;
  logic            bp_hit_q, bp_hit_d;
  logic [31:0]     tick_count_q, tick_count_d;

  logic [ADDR_W-1:0] pc_w, bp_w;
  logic              bp_match;

  assign pc_w     = bus.pc;
  assign bp_w     = bus.bp_addr;
  assign bp_match = bus.bp_enable && (pc_w == bp_w);

  // Two-flop synchronizer chains for the raw board inputs
  always_comb begin
    step_s1_d = step_n;
    step_s2_d = step_s1_q;
    run_s1_d  = run_sw;
    run_s2_d  = run_s1_q;
  end

  // Debounce: count consecutive cycles the synchronized value disagrees with
  // the accepted value; accept it on the edge the count completes.
  always_comb begin
    step_db_d  = step_db_q;
    step_cnt_d = '0;
    if (step_s2_q != step_db_q) begin
      if (step_cnt_q == DB_LAST) step_db_d = step_s2_q;
      else                       step_cnt_d = step_cnt_q + 1'b1;
    end
    run_db_d  = run_db_q;
    run_cnt_d = '0;
    if (run_s2_q != run_db_q) begin
      if (run_cnt_q == DB_LAST) run_db_d = run_s2_q;
      else                      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  // Press pulse fires on the edge the debounced button goes released->pressed
  assign step_press = step_db_q & ~step_db_d;

  // Mode FSM: next state, prescaler, tick and breakpoint flag
  always_comb begin
    state_d      = state_q;
    ret_break_d  = ret_break_q;
    presc_d      = presc_q;
    cpu_enable_d = 1'b0;
    bp_hit_d     = bp_hit_q;
    case (state_q)
      S_IDLE: begin
        if (run_db_q) begin
          state_d = S_RUN;
          presc_d = '0;
        end else if (step_press) begin
          state_d      = S_STEP;
          cpu_enable_d = 1'b1;
          ret_break_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (!run_db_q) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (presc_q == PS_LAST) begin
          presc_d = '0;
          if (bp_match) begin
            state_d  = S_BREAK;
            bp_hit_d = 1'b1;
          end else if (bus.halt_req) begin
            state_d  = S_BREAK;
            bp_hit_d = 1'b0;
          end else begin
            cpu_enable_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_STEP: begin
        // A step never checks the breakpoint, so it can walk past one.
        state_d = ret_break_q ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        if (!run_db_q) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b0;
        end else if (step_press) begin
          state_d      = S_STEP;
          cpu_enable_d = 1'b1;
          ret_break_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tick counter advances on the same edge that raises cpu_enable (wraps)
  always_comb begin
    tick_count_d = tick_count_q + {31'd0, cpu_enable_d};
  end

  // State registers; reset drops cpu_enable immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_s1_q    <= 1'b1;
      step_s2_q    <= 1'b1;
      run_s1_q     <= 1'b0;
      run_s2_q     <= 1'b0;
      step_db_q    <= 1'b1;
      step_cnt_q   <= '0;
      run_db_q     <= 1'b0;
      run_cnt_q    <= '0;
      state_q      <= S_IDLE;
      ret_break_q  <= 1'b0;
      presc_q      <= '0;
      cpu_enable_q <= 1'b0;
      bp_hit_q     <= 1'b0;
      tick_count_q <= '0;
    end else begin
      step_s1_q    <= step_s1_d;
      step_s2_q    <= step_s2_d;
      run_s1_q     <= run_s1_d;
      run_s2_q     <= run_s2_d;
      step_db_q    <= step_db_d;
      step_cnt_q   <= step_cnt_d;
      run_db_q     <= run_db_d;
      run_cnt_q    <= run_cnt_d;
      state_q      <= state_d;
      ret_break_q  <= ret_break_d;
      presc_q      <= presc_d;
      cpu_enable_q <= cpu_enable_d;
      bp_hit_q     <= bp_hit_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign bus.cpu_enable = cpu_enable_q;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == S_BREAK);
  assign bus.bp_hit     = bp_hit_q;
  assign bus.tick_count = tick_count_q;

endmodule
